// File: rtl/acia_rx.sv
// ACIA 8N1 serial receiver: synchronises rx_serial, validates the start bit and
// samples eight data bits plus the stop bit at bit centres, timed in pclk ticks.
module acia_rx #(
    parameter int clk_freq = 3333333,
    parameter int sym_rate = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pclk,
    input  logic       rx_serial,
    input  logic       rx_ack,
    output logic [7:0] rx_dat,
    output logic       rx_valid,
    output logic       rx_ferr,
    output logic       rx_ovr,
    output logic       rx_busy
);
    localparam int BIT_TICKS = clk_freq / sym_rate;
    localparam int SCW = $clog2(BIT_TICKS);
    localparam logic [SCW-1:0] HALF_LOAD = SCW'(BIT_TICKS / 2 - 1);
    localparam logic [SCW-1:0] FULL_LOAD = SCW'(BIT_TICKS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state_q, state_d;
    logic           s1_q, s1_d, s2_q, s2_d;
    logic           armed_q, armed_d;
    logic [SCW-1:0] rcnt_q, rcnt_d;
    logic [2:0]     bcnt_q, bcnt_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     rx_dat_q, rx_dat_d;
    logic           rx_valid_q, rx_valid_d;
    logic           rx_ferr_q, rx_ferr_d;
    logic           rx_ovr_q, rx_ovr_d;
    logic           rx_busy_q, rx_busy_d;

    always_comb begin
        state_d    = state_q;
        s1_d       = rx_serial;
        s2_d       = s1_q;
        armed_d    = armed_q;
        rcnt_d     = rcnt_q;
        bcnt_d     = bcnt_q;
        shift_d    = shift_q;
        rx_dat_d   = rx_dat_q;
        rx_valid_d = rx_valid_q;
        rx_ferr_d  = rx_ferr_q;
        rx_ovr_d   = rx_ovr_q;

        // The CPU acknowledge is honoured on any clk; a completing byte below overrides it.
        if (rx_ack) begin
            rx_valid_d = 1'b0;
            rx_ferr_d  = 1'b0;
            rx_ovr_d   = 1'b0;
        end

        if (pclk) begin
            case (state_q)
                IDLE: begin
                    if (armed_q && !s2_q) begin
                        state_d = START;
                        armed_d = 1'b0;
                        rcnt_d  = HALF_LOAD;
                    end else if (s2_q) begin
                        armed_d = 1'b1;
                    end
                end
                START: begin
                    if (rcnt_q == '0) begin
                        if (s2_q) begin
                            state_d = IDLE;
                            armed_d = 1'b1;
                        end else begin
                            state_d = DATA;
                            rcnt_d  = FULL_LOAD;
                            bcnt_d  = 3'd0;
                        end
                    end else begin
                        rcnt_d = rcnt_q - SCW'(1);
                    end
                end
                DATA: begin
                    if (rcnt_q == '0) begin
                        shift_d = {s2_q, shift_q[7:1]};
                        rcnt_d  = FULL_LOAD;
                        if (bcnt_q == 3'd7) state_d = STOP;
                        else                bcnt_d  = bcnt_q + 3'd1;
                    end else begin
                        rcnt_d = rcnt_q - SCW'(1);
                    end
                end
                STOP: begin
                    // Leaving at the stop-bit centre leaves half a bit to re-arm for the next start edge.
                    if (rcnt_q == '0) begin
                        state_d    = IDLE;
                        rx_dat_d   = shift_q;
                        rx_ferr_d  = ~s2_q;
                        rx_valid_d = 1'b1;
                        rx_ovr_d   = (rx_ovr_q | rx_valid_q) & ~rx_ack;
                        armed_d    = s2_q;
                    end else begin
                        rcnt_d = rcnt_q - SCW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        rx_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            armed_q    <= 1'b0;
            rcnt_q     <= '0;
            bcnt_q     <= 3'd0;
            shift_q    <= 8'h00;
            rx_dat_q   <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_busy_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            armed_q    <= armed_d;
            rcnt_q     <= rcnt_d;
            bcnt_q     <= bcnt_d;
            shift_q    <= shift_d;
            rx_dat_q   <= rx_dat_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_busy_q  <= rx_busy_d;
        end
    end

    assign rx_dat   = rx_dat_q;
    assign rx_valid = rx_valid_q;
    assign rx_ferr  = rx_ferr_q;
    assign rx_ovr   = rx_ovr_q;
    assign rx_busy  = rx_busy_q;
endmodule
